plic_gen: RTL and testbench
===========================

Name: plic_gen

Overview:
- Parametrised platform-level interrupt controller at base 0x0C000000.
- Successor to the fixed two-context, priority-less controller. Adds:
  - configurable source and context counts;
  - per-source priority and per-context threshold;
  - per-source level/edge gateways with proper claim/complete semantics.
- Sits between peripheral interrupt lines and the CPU external-interrupt inputs (context 0 = M, context 1 = S, further contexts for additional harts).

Parameters:
- NSRC, 31, number of sources; IDs 1..NSRC, ID 0 reserved "no interrupt"; NSRC max 31.
- NCTX, 2, number of contexts; max 8.
- PRIO_W, 3, priority width; priority 0 = never interrupts.
- EDGE_MASK, 32'h0, bit n=1 makes source n edge-triggered (rising); bit 0 ignored.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_addr  in  24  byte offset from base
- i_we  in  4  byte write enables; 0 = read
- i_dat_w  in  32  write data
- o_dat_r  out  32  registered read data, valid while o_ack=1
- i_stb  in  1  access request, held until o_ack
- o_ack  out  1  one-cycle acknowledge
- i_int  in  NSRC  source lines, bit k-1 = ID k, synchronous to i_clk
- o_ext_int  out  NCTX  per-context interrupt request

Behaviour:
- Reset (async): priority, enable, threshold, pending, in_service, edge_flag, o_ack, o_dat_r all 0; o_ext_int = 0.
- Register map (32-bit, word-aligned):
  - priority[id] at 0x000000+4*id, RW, low PRIO_W bits; id 0 reads 0, writes ignored.
  - pending at 0x001000, RO, bit id.
  - enable[c] at 0x002000+0x80*c, RW, bits 1..NSRC; bit 0 and bits above NSRC read 0.
  - threshold[c] at 0x200000+0x1000*c, RW, low PRIO_W bits.
  - claim/complete[c] at 0x200004+0x1000*c.
  - Unmapped offsets read 0; writes to them are ignored.
- Bus handshake:
  - Access accepted on the cycle with i_stb=1 and o_ack=0.
  - o_ack=1 on the next cycle with o_dat_r loaded; o_ack is then 0 for at least one cycle.
  - Byte enables honoured on all RW registers.
  - Side effects occur only on the accept cycle.
- Gateway per source:
  - Level: while in_service=0 and line=1, set pending.
  - Edge: a rising edge (registered previous value) sets pending if in_service=0; otherwise it sets edge_flag. One edge is remembered; further edges are dropped.
- Claim (read of claim[c]):
  - Returns ID with pending=1, enable[c]=1, priority>threshold[c], highest priority; tie goes to lowest ID.
  - If no such ID, returns 0.
  - On the accept cycle: pending[id] cleared, in_service[id] set. Claim result is sampled on the accept cycle.
- Complete (write of claim[c], any i_we bit):
  - i_dat_w[7:0]=id; if 1<=id<=NSRC and enable[c][id]=1, clears in_service[id].
  - Edge source with edge_flag set: pending set and edge_flag cleared in the same cycle.
  - Invalid or non-enabled id: ignored.
- Simultaneous events:
  - Claim-clear beats a same-cycle gateway set for the same ID, since in_service blocks re-entry.
  - Complete and a new level assertion in the same cycle: pending sets on the following cycle.
  - Two contexts cannot claim in one cycle (one bus).
  - A source claimed by one context is invisible to the others until complete.
- o_ext_int[c] is registered: 1 the cycle after any eligible ID for context c exists. Latency from i_int rise to o_ext_int is 2 cycles.
- Priority or threshold writes take effect for claim and o_ext_int from the next cycle.

Decomposition:
- Package plic_pkg:
  - offset constants: PRIO_BASE, PEND_OFF, EN_BASE, EN_STRIDE, CTX_BASE, CTX_STRIDE, CLAIM_OFF;
  - ID width constant ID_W=5.
- Sub-module plic_gateway, one instance per source.
  - Ports: clock, reset, line, edge mode, claim pulse, complete pulse.
  - Output: pending, in_service.
- Per-context max-priority selection is a combinational loop in the top level; it is not a separate module.

Test Plan:
- Reset with i_rst pulsed mid-access: o_ack=0, o_ext_int=0, all registers read 0, and no stale ack is issued afterwards.
- Priority[3]=2, priority[5]=2, enable[0]=0x28, threshold[0]=1; assert i_int IDs 3 and 5. Required response:
  - o_ext_int[0]=1 after 2 cycles;
  - claim returns 3, then 5, then 0;
  - pending reads 0x00.
- Threshold[1]=2, priority[4]=2, enable[1]=0x10, ID 4 high: o_ext_int[1] stays 0 and claim returns 0. Threshold[1]=1: o_ext_int[1]=1 and claim returns 4.
- Level source 4 held high and claimed: no re-pend before complete. After writing 4 to complete, pending bit 4 reads 1 on the following cycle.
- Edge source 6 (EDGE_MASK bit 6): 3 pulses while in service; after complete, exactly one re-pend; the second claim returns 6 and the third returns 0.
- Complete with id 0, id 32, and an id not enabled for the context: in_service unchanged, source stays blocked. Byte write of 0xFF with i_we=0001 to enable[0] sets only bits 1..7.

Source files
------------

// File: rtl/plic_pkg.sv
// Shared register-map offsets, ID width and bus helpers for the interrupt controller.
package plic_pkg;
  localparam int          ID_W       = 5;
  localparam logic [23:0] PRIO_BASE  = 24'h000000;
  localparam logic [23:0] PEND_OFF   = 24'h001000;
  localparam logic [23:0] EN_BASE    = 24'h002000;
  localparam logic [23:0] EN_STRIDE  = 24'h000080;
  localparam logic [23:0] CTX_BASE   = 24'h200000;
  localparam logic [23:0] CTX_STRIDE = 24'h001000;
  localparam logic [23:0] CLAIM_OFF  = 24'h000004;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Valid enable bits are 1..n; bit 0 is the reserved "no interrupt" ID.
  function automatic logic [31:0] src_mask(input int n);
    logic [31:0] m;
    m = '0;
    for (int i = 1; i < 32; i++) begin
      if (i <= n) m[i] = 1'b1;
    end
    return m;
  endfunction
endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: level or rising-edge capture, blocked while in service, one edge remembered.
// Claim/complete pulses act in the cycle they arrive; pending/in_service are registered.
module plic_gateway (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  input  logic i_edge,
  input  logic i_claim,
  input  logic i_complete,
  output logic o_pending,
  output logic o_in_service
);
  logic prev_q, pend_q, pend_d, insvc_q, insvc_d, flag_q, flag_d;
  logic rise, req;

  assign rise = i_line & ~prev_q;
  assign req  = i_edge ? rise : i_line;

  always_comb begin
    pend_d  = pend_q;
    insvc_d = insvc_q;
    flag_d  = flag_q;
    if (req) begin
      if (!insvc_q)    pend_d = 1'b1;
      else if (i_edge) flag_d = 1'b1;
    end
    // An edge landing on the complete cycle counts as the remembered edge.
    if (i_complete) begin
      insvc_d = 1'b0;
      flag_d  = 1'b0;
      if (flag_q || (i_edge && rise)) pend_d = 1'b1;
    end
    if (i_claim) begin
      pend_d  = 1'b0;
      insvc_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_q  <= 1'b0;
      pend_q  <= 1'b0;
      insvc_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      prev_q  <= i_line;
      pend_q  <= pend_d;
      insvc_q <= insvc_d;
      flag_q  <= flag_d;
    end
  end

  assign o_pending    = pend_q;
  assign o_in_service = insvc_q;
endmodule

// File: rtl/plic_gen.sv
// Platform-level interrupt controller with per-source priority, per-context threshold and claim/complete.
// Bus acks one cycle after accept then idles a cycle; o_ext_int is registered from gateway state.
module plic_gen
  import plic_pkg::*;
#(
  parameter int          NSRC      = 31,
  parameter int          NCTX      = 2,
  parameter int          PRIO_W    = 3,
  parameter logic [31:0] EDGE_MASK = 32'h0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [23:0]     i_addr,
  input  logic [3:0]      i_we,
  input  logic [31:0]     i_dat_w,
  output logic [31:0]     o_dat_r,
  input  logic            i_stb,
  output logic            o_ack,
  input  logic [NSRC-1:0] i_int,
  output logic [NCTX-1:0] o_ext_int
);
  localparam logic [31:0] EN_MASK = src_mask(NSRC);

  logic [PRIO_W-1:0] prio_q [1:NSRC];
  logic [PRIO_W-1:0] prio_d [1:NSRC];
  logic [31:0]       en_q   [NCTX];
  logic [31:0]       en_d   [NCTX];
  logic [PRIO_W-1:0] thr_q  [NCTX];
  logic [PRIO_W-1:0] thr_d  [NCTX];
  logic [ID_W-1:0]   best_id [NCTX];
  logic              ack_q;
  logic [31:0]       dat_q, rdata;
  logic [NCTX-1:0]   ext_q, ext_d;
  logic [NSRC:1]     pend, insvc, clm, cmpl;
  logic              accept, rd, wr;

  assign accept = i_stb & ~ack_q;
  assign rd     = accept & (i_we == 4'b0000);
  assign wr     = accept & (i_we != 4'b0000);

  for (genvar g = 1; g <= NSRC; g++) begin : g_gw
    plic_gateway u_gw (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_line      (i_int[g-1]),
      .i_edge      (EDGE_MASK[g]),
      .i_claim     (clm[g]),
      .i_complete  (cmpl[g]),
      .o_pending   (pend[g]),
      .o_in_service(insvc[g])
    );
  end

  // Highest priority wins; strict compare keeps the lowest ID on ties.
  always_comb begin
    logic [PRIO_W-1:0] bp;
    best_id = '{default: '0};
    ext_d   = '0;
    bp      = '0;
    for (int c = 0; c < NCTX; c++) begin
      bp = '0;
      for (int s = 1; s <= NSRC; s++) begin
        if (pend[s] && !insvc[s] && en_q[c][s] && (prio_q[s] > thr_q[c])) begin
          ext_d[c] = 1'b1;
          if (prio_q[s] > bp) begin
            bp         = prio_q[s];
            best_id[c] = ID_W'(s);
          end
        end
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    en_d   = en_q;
    thr_d  = thr_q;
    rdata  = '0;
    clm    = '0;
    cmpl   = '0;
    if (i_addr[1:0] == 2'b00) begin
      for (int s = 1; s <= NSRC; s++) begin
        if (i_addr == PRIO_BASE + 24'(4 * s)) begin
          rdata = 32'(prio_q[s]);
          if (wr) prio_d[s] = PRIO_W'(be_merge(32'(prio_q[s]), i_dat_w, i_we));
        end
      end
      if (i_addr == PEND_OFF) begin
        for (int s = 1; s <= NSRC; s++) rdata[s] = pend[s];
      end
      for (int c = 0; c < NCTX; c++) begin
        if (i_addr == EN_BASE + 24'(EN_STRIDE * c)) begin
          rdata = en_q[c];
          if (wr) en_d[c] = be_merge(en_q[c], i_dat_w, i_we) & EN_MASK;
        end
        if (i_addr == CTX_BASE + 24'(CTX_STRIDE * c)) begin
          rdata = 32'(thr_q[c]);
          if (wr) thr_d[c] = PRIO_W'(be_merge(32'(thr_q[c]), i_dat_w, i_we));
        end
        if (i_addr == CTX_BASE + 24'(CTX_STRIDE * c) + CLAIM_OFF) begin
          rdata = 32'(best_id[c]);
          for (int s = 1; s <= NSRC; s++) begin
            if (rd && best_id[c] == ID_W'(s)) clm[s] = 1'b1;
            if (wr && i_dat_w[7:0] == 8'(s) && en_q[c][s]) cmpl[s] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prio_q <= '{default: '0};
      en_q   <= '{default: '0};
      thr_q  <= '{default: '0};
      ack_q  <= 1'b0;
      dat_q  <= '0;
      ext_q  <= '0;
    end else begin
      prio_q <= prio_d;
      en_q   <= en_d;
      thr_q  <= thr_d;
      ack_q  <= accept;
      if (accept) dat_q <= rd ? rdata : '0;
      ext_q  <= ext_d;
    end
  end

  assign o_ack     = ack_q;
  assign o_dat_r   = dat_q;
  assign o_ext_int = ext_q;
endmodule

// File: tb/tb_plic_gen.sv
// Bench for plic_gen: event-level reference model compared every cycle, directed scenarios, random traffic.
module tb_plic_gen;
  localparam int          NSRC  = 31;
  localparam int          NCTX  = 2;
  localparam logic [31:0] EMASK = 32'h0000_0840;

  logic        clk, rst, stb, ack;
  logic [23:0] addr;
  logic [3:0]  we;
  logic [31:0] wdat, rdat;
  logic [30:0] int_lines;
  logic [1:0]  ext;

  int checks = 0;
  int failures = 0;
  logic cmp_on = 1'b0;

  plic_gen #(.NSRC(NSRC), .NCTX(NCTX), .PRIO_W(3), .EDGE_MASK(EMASK)) dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_we(we), .i_dat_w(wdat), .o_dat_r(rdat),
    .i_stb(stb), .o_ack(ack), .i_int(int_lines), .o_ext_int(ext)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: indexed by source ID, bit/entry 0 unused.
  logic [2:0]  m_prio [32];
  logic [31:0] m_en [2];
  logic [2:0]  m_thr [2];
  logic [31:0] m_pend, m_insvc, m_flag, m_prev;
  logic        m_ack;
  logic [31:0] m_rdat;
  logic [1:0]  m_ext;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic int m_best(input int c);
    int b, bp;
    b = 0;
    bp = 0;
    for (int id = 1; id <= NSRC; id++)
      if (m_pend[id] && m_en[c][id] && m_prio[id] > m_thr[c] && int'(m_prio[id]) > bp) begin
        b = id;
        bp = int'(m_prio[id]);
      end
    return b;
  endfunction

  // kind: 0 unmapped, 1 priority, 2 pending, 3 enable, 4 threshold, 5 claim
  task automatic m_decode(input logic [23:0] a, output int kind, output int idx);
    int ai;
    ai = int'(a);
    kind = 0;
    idx = 0;
    if (ai % 4 == 0) begin
      if (ai < 'h1000) begin
        if (ai / 4 >= 1 && ai / 4 <= NSRC) begin kind = 1; idx = ai / 4; end
      end else if (ai == 'h1000) kind = 2;
      else if (ai >= 'h2000 && ai < 'h2000 + 'h80 * NCTX && (ai - 'h2000) % 'h80 == 0) begin
        kind = 3; idx = (ai - 'h2000) / 'h80;
      end else if (ai >= 'h200000 && ai < 'h200000 + 'h1000 * NCTX) begin
        idx = (ai - 'h200000) / 'h1000;
        if (ai % 'h1000 == 0) kind = 4;
        else if (ai % 'h1000 == 4) kind = 5;
      end
    end
  endtask

  task automatic model_step();
    int kind, idx, clm_id, cmp_id, nx;
    logic acc;
    logic [31:0] rv, nv;
    logic [1:0] ext_n;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_prio[i] = '0;
      m_en[0] = '0; m_en[1] = '0; m_thr[0] = '0; m_thr[1] = '0;
      m_pend = '0; m_insvc = '0; m_flag = '0; m_prev = '0;
      m_ack = 1'b0; m_rdat = '0; m_ext = '0;
    end else begin
      acc = stb && !m_ack;
      for (int c = 0; c < NCTX; c++) ext_n[c] = (m_best(c) != 0);
      clm_id = 0; cmp_id = 0; rv = '0;
      if (acc) begin
        m_decode(addr, kind, idx);
        case (kind)
          1: begin
            rv = 32'(m_prio[idx]);
            if (we != 0) begin nv = merge(rv, wdat, we); m_prio[idx] = nv[2:0]; end
          end
          2: rv = m_pend;
          3: begin
            rv = m_en[idx];
            if (we != 0) m_en[idx] = merge(rv, wdat, we) & 32'hFFFF_FFFE;
          end
          4: begin
            rv = 32'(m_thr[idx]);
            if (we != 0) begin nv = merge(rv, wdat, we); m_thr[idx] = nv[2:0]; end
          end
          5: begin
            if (we == 0) begin clm_id = m_best(idx); rv = clm_id; end
            else begin
              nx = int'(wdat[7:0]);
              if (nx >= 1 && nx <= NSRC && m_en[idx][nx]) cmp_id = nx;
            end
          end
          default: rv = '0;
        endcase
      end
      for (int id = 1; id <= NSRC; id++) begin
        if (EMASK[id]) begin
          if (int_lines[id-1] && !m_prev[id]) begin
            if (!m_insvc[id]) m_pend[id] = 1'b1; else m_flag[id] = 1'b1;
          end
        end else if (int_lines[id-1] && !m_insvc[id]) m_pend[id] = 1'b1;
        m_prev[id] = int_lines[id-1];
        if (id == cmp_id) begin
          m_insvc[id] = 1'b0;
          if (m_flag[id]) begin m_pend[id] = 1'b1; m_flag[id] = 1'b0; end
        end
        if (id == clm_id) begin m_pend[id] = 1'b0; m_insvc[id] = 1'b1; end
      end
      m_ack = acc;
      if (acc) m_rdat = (we == 0) ? rv : 32'h0;
      m_ext = ext_n;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      chk("ack", 32'(ack), 32'(m_ack));
      chk("ext_int", 32'(ext), 32'(m_ext));
      if (m_ack) chk("rdata", rdat, m_rdat);
    end
  end

  function automatic logic [23:0] a_prio(input int id); return 24'(4 * id); endfunction
  function automatic logic [23:0] a_en(input int c);    return 24'('h2000 + 'h80 * c); endfunction
  function automatic logic [23:0] a_thr(input int c);   return 24'('h200000 + 'h1000 * c); endfunction
  function automatic logic [23:0] a_clm(input int c);   return 24'('h200004 + 'h1000 * c); endfunction
  localparam logic [23:0] A_PEND = 24'h001000;

  task automatic bus(input logic [23:0] a, input logic [3:0] be, input logic [31:0] d, output logic [31:0] r);
    int n;
    n = 0;
    @(posedge clk); #1;
    stb = 1'b1; addr = a; we = be; wdat = d;
    do begin @(negedge clk); n++; end while (!ack && n < 20);
    if (!ack) begin
      checks++; failures++;
      $display("FAIL bus_timeout: no ack for addr 0x%0h, expected ack within 20 cycles", a);
    end
    r = rdat;
    @(posedge clk); #1;
    stb = 1'b0; we = '0;
  endtask

  task automatic wr(input logic [23:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    bus(a, be, d, r);
  endtask

  task automatic rd_chk(input string nm, input logic [23:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(a, 4'b0000, 32'h0, r);
    chk(nm, r, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int id);
    int_lines[id-1] = 1'b1; cyc(1);
    int_lines[id-1] = 1'b0; cyc(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int op, c;
    rst = 1'b1; stb = 1'b0; addr = '0; we = '0; wdat = '0; int_lines = '0;
    cyc(3);
    rst = 1'b0; cmp_on = 1'b1;
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_ext", 32'(ext), 32'h0);

    // Reset pulsed while an access is being acknowledged.
    @(posedge clk); #1;
    stb = 1'b1; addr = a_prio(3); we = 4'hF; wdat = 32'h5;
    @(posedge clk); #1;
    rst = 1'b1; stb = 1'b0; we = '0;
    #1;
    chk("midrst_ack", 32'(ack), 32'h0);
    chk("midrst_ext", 32'(ext), 32'h0);
    cyc(2);
    rst = 1'b0;
    repeat (3) begin @(negedge clk); chk("no_stale_ack", 32'(ack), 32'h0); end
    rd_chk("rst_prio3", a_prio(3), 32'h0);
    rd_chk("rst_en0", a_en(0), 32'h0);
    rd_chk("rst_thr0", a_thr(0), 32'h0);
    rd_chk("rst_pend", A_PEND, 32'h0);
    rd_chk("rst_claim0", a_clm(0), 32'h0);

    // Equal priorities on IDs 3 and 5: lowest ID first.
    wr(a_prio(3), 32'd2, 4'hF);
    wr(a_prio(5), 32'd2, 4'hF);
    wr(a_en(0), 32'h28, 4'hF);
    wr(a_thr(0), 32'd1, 4'hF);
    int_lines[2] = 1'b1; int_lines[4] = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("lat_ext0_c1", 32'(ext[0]), 32'h0);
    @(negedge clk);
    chk("lat_ext0_c2", 32'(ext[0]), 32'h1);
    cyc(1);
    rd_chk("claim_a", a_clm(0), 32'd3);
    rd_chk("claim_b", a_clm(0), 32'd5);
    rd_chk("claim_c", a_clm(0), 32'd0);
    rd_chk("pend_empty", A_PEND, 32'h0);
    int_lines[2] = 1'b0; int_lines[4] = 1'b0;
    wr(a_clm(0), 32'd3, 4'hF);
    wr(a_clm(0), 32'd5, 4'hF);

    // Threshold gating on context 1.
    wr(a_thr(1), 32'd2, 4'hF);
    wr(a_prio(4), 32'd2, 4'hF);
    wr(a_en(1), 32'h10, 4'hF);
    int_lines[3] = 1'b1;
    cyc(4);
    chk("thr_block_ext1", 32'(ext[1]), 32'h0);
    rd_chk("thr_block_claim", a_clm(1), 32'd0);
    wr(a_thr(1), 32'd1, 4'hF);
    cyc(2);
    chk("thr_open_ext1", 32'(ext[1]), 32'h1);
    rd_chk("thr_open_claim", a_clm(1), 32'd4);

    // Level source held high across claim: no re-pend until complete.
    cyc(2);
    rd_chk("lvl_no_repend", A_PEND, 32'h0);
    wr(a_clm(1), 32'd4, 4'hF);
    rd_chk("lvl_repend", A_PEND, 32'h10);
    int_lines[3] = 1'b0;
    rd_chk("lvl_claim2", a_clm(1), 32'd4);
    wr(a_clm(1), 32'd4, 4'hF);

    // Invalid completes leave the source blocked.
    wr(a_en(1), 32'h0, 4'hF);
    wr(a_en(0), 32'h10, 4'hF);
    int_lines[3] = 1'b1;
    cyc(2);
    rd_chk("inv_claim", a_clm(0), 32'd4);
    wr(a_clm(0), 32'd0, 4'hF);
    wr(a_clm(0), 32'd32, 4'hF);
    wr(a_clm(1), 32'd4, 4'h1);
    cyc(2);
    rd_chk("inv_pend", A_PEND, 32'h0);
    rd_chk("inv_claim0", a_clm(0), 32'd0);
    wr(a_clm(0), 32'd4, 4'h2);
    rd_chk("valid_cmpl_pend", A_PEND, 32'h10);
    int_lines[3] = 1'b0;
    rd_chk("valid_claim", a_clm(0), 32'd4);
    wr(a_clm(0), 32'd4, 4'hF);
    wr(a_en(0), 32'h0, 4'hF);
    wr(a_en(0), 32'hFFFF_FFFF, 4'b0001);
    rd_chk("byte_en", a_en(0), 32'hFE);

    // Edge source 6: several edges while in service collapse to one.
    wr(a_en(0), 32'h40, 4'hF);
    wr(a_prio(6), 32'd3, 4'hF);
    pulse(6);
    rd_chk("edge_claim1", a_clm(0), 32'd6);
    pulse(6); pulse(6); pulse(6);
    rd_chk("edge_insvc_pend", A_PEND, 32'h0);
    wr(a_clm(0), 32'd6, 4'hF);
    rd_chk("edge_repend", A_PEND, 32'h40);
    rd_chk("edge_claim2", a_clm(0), 32'd6);
    wr(a_clm(0), 32'd6, 4'hF);
    rd_chk("edge_claim3", a_clm(0), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int_lines = int_lines ^ 31'($urandom & $urandom & $urandom);
      op = $urandom_range(0, 7);
      c = $urandom_range(0, 1);
      case (op)
        0: wr(a_prio($urandom_range(0, 31)), $urandom, 4'($urandom_range(1, 15)));
        1: wr(a_en($urandom_range(0, 2)), $urandom, 4'($urandom_range(1, 15)));
        2: wr(a_thr(c), $urandom, 4'($urandom_range(1, 15)));
        3, 4: bus(a_clm(c), 4'b0000, 32'h0, r);
        5: wr(a_clm(c), ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 33)), 4'($urandom_range(1, 15)));
        6: bus(A_PEND, 4'b0000, 32'h0, r);
        default: begin
          if ($urandom_range(0, 1) == 1) bus(24'($urandom_range('h200000, 'h202010)), 4'($urandom_range(0, 15)), $urandom, r);
          else bus(24'($urandom_range(0, 'h2110)), 4'($urandom_range(0, 15)), $urandom, r);
        end
      endcase
      if ($urandom_range(0, 3) == 0) cyc($urandom_range(1, 3));
    end
    cyc(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
